// File: rtl/alu_ctrl_mdu_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : alu_ctrl_mdu_seq_pkg                                           |
// | Purpose : Shared codes for the ALU control unit and its MDU sequencer:   |
// |           ALUOp classes, ALU operation codes, R-type function codes,     |
// |           HiLo select codes and the sequencer state encoding.            |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package alu_ctrl_mdu_seq_pkg;

   // ALUOp classes issued by the main control unit
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   // ALU operation codes
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // R-type function field codes
   localparam logic [5:0] FUNCT_MFHI  = 6'd16;
   localparam logic [5:0] FUNCT_MFLO  = 6'd18;
   localparam logic [5:0] FUNCT_MULTU = 6'd25;
   localparam logic [5:0] FUNCT_DIVU  = 6'd27;
   localparam logic [5:0] FUNCT_ADD   = 6'd32;
   localparam logic [5:0] FUNCT_SUB   = 6'd34;
   localparam logic [5:0] FUNCT_AND   = 6'd36;
   localparam logic [5:0] FUNCT_OR    = 6'd37;
   localparam logic [5:0] FUNCT_SLT   = 6'd42;

   // Write-back source select
   localparam logic [1:0] SELHILO_ALU = 2'b00;
   localparam logic [1:0] SELHILO_HI  = 2'b01;
   localparam logic [1:0] SELHILO_LO  = 2'b10;

   // MDU sequencer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_STEP  = 2'd2,
      ST_WB    = 2'd3
   } mdu_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_mdu_seq_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : alu_ctrl_mdu_seq_decode                                        |
// | Purpose : Pure combinational ALUOp/Funct decode. Produces the ALU        |
// |           operation, the HiLo write-back select, the illegal flag and    |
// |           the class flags the sequencer needs (MDU request, HiLo read).  |
// | Ports   : ALUOp[1:0], Funct[5:0]            in                           |
// |           ALUOperation[2:0], SelHilo[1:0]    out                          |
// |           illegal, mdu_req, mdu_div, hilo_read out                        |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module alu_ctrl_mdu_seq_decode
   import alu_ctrl_mdu_seq_pkg::*;
#(
   parameter int HAS_DIV = 1
) (
   input  logic [1:0] ALUOp,
   input  logic [5:0] Funct,
   output logic [2:0] ALUOperation,
   output logic [1:0] SelHilo,
   output logic       illegal,
   output logic       mdu_req,
   output logic       mdu_div,
   output logic       hilo_read
);

   always_comb begin
      // Safe defaults: every undecodable path falls back to AND/ALU with the
      // illegal flag raised, so no X ever reaches the datapath.
      ALUOperation = ALU_AND;
      SelHilo      = SELHILO_ALU;
      illegal      = 1'b0;
      mdu_req      = 1'b0;
      mdu_div      = 1'b0;
      hilo_read    = 1'b0;
      case (ALUOp)
         ALUOP_ADD: ALUOperation = ALU_ADD;
         ALUOP_SUB: ALUOperation = ALU_SUB;
         ALUOP_RTYPE: begin
            case (Funct)
               FUNCT_ADD:   ALUOperation = ALU_ADD;
               FUNCT_SUB:   ALUOperation = ALU_SUB;
               FUNCT_AND:   ALUOperation = ALU_AND;
               FUNCT_OR:    ALUOperation = ALU_OR;
               FUNCT_SLT:   ALUOperation = ALU_SLT;
               FUNCT_MFHI: begin
                  SelHilo   = SELHILO_HI;
                  hilo_read = 1'b1;
               end
               FUNCT_MFLO: begin
                  SelHilo   = SELHILO_LO;
                  hilo_read = 1'b1;
               end
               FUNCT_MULTU: mdu_req = 1'b1;
               FUNCT_DIVU: begin
                  if (HAS_DIV != 0) begin
                     mdu_req = 1'b1;
                     mdu_div = 1'b1;
                  end else begin
                     illegal = 1'b1;
                  end
               end
               default:     illegal = 1'b1;
            endcase
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_mdu_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : alu_ctrl_mdu_seq                                               |
// | Purpose : ALU control unit with a sequencer for multi-cycle MULTU/DIVU.  |
// |           Decode is combinational; the sequencer walks IDLE -> START ->  |
// |           STEP (WIDTH cycles) -> WB and interlocks the pipeline against  |
// |           new MDU ops and HiLo reads while it is busy.                   |
// | Ports   : clk, rst (async, active high), inst_valid, ALUOp[1:0],         |
// |           Funct[5:0]                                         in          |
// |           ALUOperation[2:0], SelHilo[1:0], illegal            out (comb)  |
// |           mdu_start, mdu_op, mdu_step, hilo_we                out (reg)   |
// |           busy, stall                                         out (comb)  |
// | Params  : WIDTH   operand width = number of step cycles                  |
// |           CNT_W   step counter width, 2**CNT_W must exceed WIDTH         |
// |           HAS_DIV 1 enables DIVU, 0 decodes it as illegal                |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module alu_ctrl_mdu_seq
   import alu_ctrl_mdu_seq_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int CNT_W   = 6,
   parameter int HAS_DIV = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inst_valid,
   input  logic [1:0] ALUOp,
   input  logic [5:0] Funct,
   output logic [2:0] ALUOperation,
   output logic [1:0] SelHilo,
   output logic       illegal,
   output logic       mdu_start,
   output logic       mdu_op,
   output logic       mdu_step,
   output logic       hilo_we,
   output logic       busy,
   output logic       stall
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   logic             dec_mdu_req;
   logic             dec_mdu_div;
   logic             dec_hilo_read;
   logic             issue;
   mdu_state_t       state;
   mdu_state_t       state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             mdu_op_next;

   alu_ctrl_mdu_seq_decode #(
      .HAS_DIV (HAS_DIV)
   ) u_decode (
      .ALUOp        (ALUOp),
      .Funct        (Funct),
      .ALUOperation (ALUOperation),
      .SelHilo      (SelHilo),
      .illegal      (illegal),
      .mdu_req      (dec_mdu_req),
      .mdu_div      (dec_mdu_div),
      .hilo_read    (dec_hilo_read)
   );

   assign busy  = (state != ST_IDLE);
   // Only an idle sequencer accepts an op; anything arriving while busy is
   // held by stall and is accepted in the first IDLE cycle.
   assign issue = inst_valid & dec_mdu_req & ~busy;
   // HiLo reads wait through WB as well, so they see the freshly written value.
   assign stall = busy & inst_valid & (dec_mdu_req | dec_hilo_read);

   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      mdu_op_next = mdu_op;
      case (state)
         ST_IDLE: begin
            if (issue) begin
               state_next  = ST_START;
               mdu_op_next = dec_mdu_div;
            end
         end
         ST_START: begin
            state_next = ST_STEP;
            cnt_next   = '0;
         end
         ST_STEP: begin
            cnt_next = cnt + 1'b1;
            if (cnt == CNT_LAST) begin
               state_next = ST_WB;
            end
         end
         ST_WB:   state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   // Strobes are registered from the next state so that each one is high
   // exactly while the sequencer sits in the matching state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         mdu_op    <= 1'b0;
         mdu_start <= 1'b0;
         mdu_step  <= 1'b0;
         hilo_we   <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         mdu_op    <= mdu_op_next;
         mdu_start <= (state_next == ST_START);
         mdu_step  <= (state_next == ST_STEP);
         hilo_we   <= (state_next == ST_WB);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_mdu_seq.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module  : tb_alu_ctrl_mdu_seq                                            |
// | Purpose : Directed self-checking bench for alu_ctrl_mdu_seq with a       |
// |           HAS_DIV=1 instance and a HAS_DIV=0 instance on shared inputs.  |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_alu_ctrl_mdu_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       inst_valid;
   logic [1:0] ALUOp;
   logic [5:0] Funct;

   logic [2:0] ALUOperation;
   logic [1:0] SelHilo;
   logic       illegal, mdu_start, mdu_op, mdu_step, hilo_we, busy, stall;

   logic [2:0] nd_ALUOperation;
   logic [1:0] nd_SelHilo;
   logic       nd_illegal, nd_mdu_start, nd_mdu_op, nd_mdu_step, nd_hilo_we;
   logic       nd_busy, nd_stall;

   int checks = 0;
   int errors = 0;
   int steps;
   int wes;
   int op_bad;

   always #5 clk = ~clk;

   alu_ctrl_mdu_seq #(.WIDTH(32), .CNT_W(6), .HAS_DIV(1)) dut (
      .clk          (clk),
      .rst          (rst),
      .inst_valid   (inst_valid),
      .ALUOp        (ALUOp),
      .Funct        (Funct),
      .ALUOperation (ALUOperation),
      .SelHilo      (SelHilo),
      .illegal      (illegal),
      .mdu_start    (mdu_start),
      .mdu_op       (mdu_op),
      .mdu_step     (mdu_step),
      .hilo_we      (hilo_we),
      .busy         (busy),
      .stall        (stall)
   );

   alu_ctrl_mdu_seq #(.WIDTH(32), .CNT_W(6), .HAS_DIV(0)) dut_nd (
      .clk          (clk),
      .rst          (rst),
      .inst_valid   (inst_valid),
      .ALUOp        (ALUOp),
      .Funct        (Funct),
      .ALUOperation (nd_ALUOperation),
      .SelHilo      (nd_SelHilo),
      .illegal      (nd_illegal),
      .mdu_start    (nd_mdu_start),
      .mdu_op       (nd_mdu_op),
      .mdu_step     (nd_mdu_step),
      .hilo_we      (nd_hilo_we),
      .busy         (nd_busy),
      .stall        (nd_stall)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic dec(input string tag, input logic [1:0] op, input logic [5:0] fn,
                      input logic [2:0] exp_op, input logic [1:0] exp_sel, input logic exp_ill);
      ALUOp = op;
      Funct = fn;
      #1;
      check({tag, "_aluop"}, 32'(ALUOperation), 32'(exp_op));
      check({tag, "_sel"},   32'(SelHilo),      32'(exp_sel));
      check({tag, "_ill"},   32'(illegal),      32'(exp_ill));
   endtask

   initial begin
      rst        = 1'b1;
      inst_valid = 1'b0;
      ALUOp      = 2'b00;
      Funct      = 6'd0;
      #12;
      check("rst_busy",  32'(busy),      32'd0);
      check("rst_start", 32'(mdu_start), 32'd0);
      check("rst_step",  32'(mdu_step),  32'd0);
      check("rst_we",    32'(hilo_we),   32'd0);
      check("rst_op",    32'(mdu_op),    32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Combinational decode, sequencer idle
      dec("add_class", 2'b00, 6'd34, 3'b010, 2'b00, 1'b0);
      dec("sub_class", 2'b01, 6'd32, 3'b110, 2'b00, 1'b0);
      dec("op11",      2'b11, 6'd32, 3'b000, 2'b00, 1'b1);
      dec("f_add",     2'b10, 6'd32, 3'b010, 2'b00, 1'b0);
      dec("f_sub",     2'b10, 6'd34, 3'b110, 2'b00, 1'b0);
      dec("f_and",     2'b10, 6'd36, 3'b000, 2'b00, 1'b0);
      dec("f_or",      2'b10, 6'd37, 3'b001, 2'b00, 1'b0);
      dec("f_slt",     2'b10, 6'd42, 3'b111, 2'b00, 1'b0);
      dec("f_63",      2'b10, 6'd63, 3'b000, 2'b00, 1'b1);
      dec("f_mfhi",    2'b10, 6'd16, 3'b000, 2'b01, 1'b0);
      dec("f_mflo",    2'b10, 6'd18, 3'b000, 2'b10, 1'b0);
      dec("f_multu",   2'b10, 6'd25, 3'b000, 2'b00, 1'b0);
      dec("f_divu",    2'b10, 6'd27, 3'b000, 2'b00, 1'b0);
      check("nd_divu_ill", 32'(nd_illegal), 32'd1);

      // MULTU timeline: start in 1, steps 2..33, hilo_we in 34
      tick();
      inst_valid = 1'b1;
      ALUOp      = 2'b10;
      Funct      = 6'd25;
      #1;
      check("issue_nostall", 32'(stall), 32'd0);
      tick();
      inst_valid = 1'b0;
      for (int c = 1; c <= 36; c++) begin
         check($sformatf("mul_start_c%0d", c), 32'(mdu_start), 32'(c == 1));
         check($sformatf("mul_step_c%0d", c),  32'(mdu_step),  32'(c >= 2 && c <= 33));
         check($sformatf("mul_we_c%0d", c),    32'(hilo_we),   32'(c == 34));
         check($sformatf("mul_op_c%0d", c),    32'(mdu_op),    32'd0);
         check($sformatf("mul_busy_c%0d", c),  32'(busy),      32'(c <= 34));
         tick();
      end

      // MULTU then MFLO held from cycle 1: stalled through WB, free in 35
      inst_valid = 1'b1;
      Funct      = 6'd25;
      tick();
      Funct = 6'd18;
      for (int c = 1; c <= 35; c++) begin
         #1;
         check($sformatf("mflo_stall_c%0d", c), 32'(stall),   32'(c <= 34));
         check($sformatf("mflo_sel_c%0d", c),   32'(SelHilo), 32'd2);
         tick();
      end
      inst_valid = 1'b0;
      tick();

      // MULTU then DIVU held from cycle 1: DIVU issues when busy drops
      inst_valid = 1'b1;
      Funct      = 6'd25;
      tick();
      Funct = 6'd27;
      #1;
      check("nd_divu_ill_busy", 32'(nd_illegal),      32'd1);
      check("nd_divu_aluop",    32'(nd_ALUOperation), 32'd0);
      check("nd_divu_nostall",  32'(nd_stall),        32'd0);
      for (int c = 1; c <= 35; c++) begin
         #1;
         check($sformatf("divu_stall_c%0d", c), 32'(stall), 32'(c <= 34));
         tick();
      end
      inst_valid = 1'b0;
      check("divu_start",    32'(mdu_start), 32'd1);
      check("divu_op",       32'(mdu_op),    32'd1);
      check("nd_no_issue",   32'(nd_busy),   32'd0);
      check("nd_no_start",   32'(nd_mdu_start), 32'd0);
      steps  = 0;
      wes    = 0;
      op_bad = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (mdu_step) steps++;
         if (hilo_we) wes++;
         if (busy && mdu_op !== 1'b1) op_bad++;
      end
      check("divu_steps",  32'(steps),  32'd32);
      check("divu_wes",    32'(wes),    32'd1);
      check("divu_op_held", 32'(op_bad), 32'd0);
      check("divu_done",   32'(busy),   32'd0);

      // MULTU with ALUOp/Funct scrambled during the operation
      inst_valid = 1'b1;
      ALUOp      = 2'b10;
      Funct      = 6'd25;
      tick();
      steps  = 0;
      wes    = 0;
      op_bad = 0;
      for (int c = 0; c < 40; c++) begin
         ALUOp = 2'($urandom_range(0, 3));
         Funct = 6'($urandom_range(0, 63));
         if (Funct == 6'd25 || Funct == 6'd27) Funct = 6'd0;
         if (mdu_step) steps++;
         if (hilo_we) wes++;
         if (mdu_op !== 1'b0) op_bad++;
         tick();
      end
      inst_valid = 1'b0;
      check("rnd_steps", 32'(steps),  32'd32);
      check("rnd_wes",   32'(wes),    32'd1);
      check("rnd_op",    32'(op_bad), 32'd0);
      check("rnd_idle",  32'(busy),   32'd0);

      // Asynchronous reset in the middle of a DIVU
      inst_valid = 1'b1;
      ALUOp      = 2'b10;
      Funct      = 6'd27;
      tick();
      inst_valid = 1'b0;
      repeat (10) tick();
      check("pre_rst_step", 32'(mdu_step), 32'd1);
      check("pre_rst_op",   32'(mdu_op),   32'd1);
      #2;
      rst = 1'b1;
      #1;
      check("arst_busy",  32'(busy),      32'd0);
      check("arst_step",  32'(mdu_step),  32'd0);
      check("arst_op",    32'(mdu_op),    32'd0);
      check("arst_start", 32'(mdu_start), 32'd0);
      check("arst_we",    32'(hilo_we),   32'd0);
      @(negedge clk);
      rst   = 1'b0;
      wes   = 0;
      steps = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (hilo_we) wes++;
         if (busy) steps++;
      end
      check("post_rst_we",   32'(wes),   32'd0);
      check("post_rst_busy", 32'(steps), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
